// File: rtl/chip_io_pkg.sv
// Shared chip I/O types: frame/channel widths, capture word payload and FSM state.
`timescale 1ns/1ps
package chip_io_pkg;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned CHAN_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } cap_state_t;

   typedef struct packed {
      logic [CHAN_W-1:0] chan;
      logic [WORD_W-1:0] data;
   } capture_word_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/readout_fifo.sv
// Synchronous FIFO of tagged capture words with a registered head; a push while
// full is still accepted when a pop happens in the same cycle.
`timescale 1ns/1ps
module readout_fifo
   import chip_io_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned LVL_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  capture_word_t     wdata,
   input  logic              pop,
   output capture_word_t     head,
   output logic              valid,
   output logic [LVL_W-1:0]  level,
   output logic              accept_c
);

   capture_word_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_nxt_c;
   logic [LVL_W-1:0] level_nxt_c;
   logic             full_c;
   logic             pop_c;

   always_comb begin
      full_c      = (level == LVL_W'(DEPTH));
      pop_c       = pop & valid;
      accept_c    = push & (~full_c | pop_c);
      rd_nxt_c    = rd_ptr + PTR_W'(1);
      level_nxt_c = level + LVL_W'(accept_c) - LVL_W'(pop_c);
   end

   // Storage needs no reset: the head register and level gate visibility.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         valid  <= 1'b0;
         head   <= '0;
      end else begin
         if (accept_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_nxt_c;
         end
         level <= level_nxt_c;
         valid <= (level_nxt_c != '0);
         // Head follows the oldest entry; a lone entry popped with a push hands over to the new word.
         if (pop_c) begin
            if (level > LVL_W'(1)) begin
               head <= mem[rd_nxt_c];
            end else if (accept_c) begin
               head <= wdata;
            end
         end else if ((level == '0) && accept_c) begin
            head <= wdata;
         end
      end
   end

endmodule

// File: rtl/readout_capture.sv
// Deserializes the chip's sdout line per 8-bit frame, tags it with the channel address
// latched at frame start and queues it behind a valid/ready port. Option: READOUT_COMPARE_EN.
`timescale 1ns/1ps
module readout_capture
   import chip_io_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1,
   localparam int unsigned CNT_W = $clog2(WORD_W)
) (
   input  logic              clk_in,
   input  logic              resn,
   input  logic              en,
   input  logic              sdout,
   input  logic [CHAN_W-1:0] sel,
   input  logic              clr_ovf,
   input  logic              out_ready,
`ifdef READOUT_COMPARE_EN
   input  logic [WORD_W-1:0] exp_data,
   output logic              mismatch,
   output logic [15:0]       err_count,
`endif
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic [CHAN_W-1:0] out_chan,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              overflow,
   output logic              abort,
   output logic [31:0]       word_count
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   cap_state_t        state;
   cap_state_t        state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] shift;
   logic [CHAN_W-1:0] chan_tag;
   logic              push_pend;
   capture_word_t     pend_word;
   capture_word_t     head;
   logic              accept_c;
   logic              drop_c;
   logic              sample_c;
   logic              first_c;
   logic              last_c;
   logic              abort_c;
   logic [WORD_W-1:0] word_c;

   always_ff @(posedge clk_in or negedge resn) begin
      if (!resn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      if (en) begin
         state_nxt = ST_SHIFT;
      end
   end

   // Frame decode: first/last bit strobes, and abort when en falls inside a frame.
   always_comb begin
      sample_c = 1'b0;
      first_c  = 1'b0;
      last_c   = 1'b0;
      abort_c  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            sample_c = en;
            first_c  = en;
         end
         ST_SHIFT: begin
            sample_c = en;
            first_c  = en & (bit_cnt == '0);
            last_c   = en & (bit_cnt == LAST_BIT);
            abort_c  = ~en & (bit_cnt != '0);
         end
         default: begin
            sample_c = 1'b0;
         end
      endcase
   end

   assign word_c = {shift[WORD_W-2:0], sdout};

   always_ff @(posedge clk_in or negedge resn) begin
      if (!resn) begin
         bit_cnt   <= '0;
         shift     <= '0;
         chan_tag  <= '0;
         push_pend <= 1'b0;
         pend_word <= '0;
         abort     <= 1'b0;
      end else begin
         abort     <= abort_c;
         push_pend <= last_c;
         if (sample_c) begin
            shift   <= word_c;
            bit_cnt <= last_c ? '0 : bit_cnt + CNT_W'(1);
            if (first_c) begin
               chan_tag <= sel;
            end
         end else begin
            bit_cnt <= '0;
            shift   <= '0;
         end
         if (last_c) begin
            pend_word.chan <= chan_tag;
            pend_word.data <= word_c;
         end
      end
   end

   readout_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk_in),
      .rst_n    (resn),
      .push     (push_pend),
      .wdata    (pend_word),
      .pop      (out_ready),
      .head     (head),
      .valid    (out_valid),
      .level    (fifo_level),
      .accept_c (accept_c)
   );

   assign out_data = head.data;
   assign out_chan = head.chan;
   assign drop_c   = push_pend & ~accept_c;

   // A drop in the same cycle as clr_ovf keeps the flag set.
   always_ff @(posedge clk_in or negedge resn) begin
      if (!resn) begin
         overflow   <= 1'b0;
         word_count <= '0;
      end else begin
         if (drop_c) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
         if (accept_c) begin
            word_count <= word_count + 32'd1;
         end
      end
   end

`ifdef READOUT_COMPARE_EN
   // Compare runs on frame completion regardless of whether the FIFO accepts the word.
   always_ff @(posedge clk_in or negedge resn) begin
      if (!resn) begin
         mismatch  <= 1'b0;
         err_count <= '0;
      end else begin
         mismatch <= 1'b0;
         if (last_c && (word_c != exp_data)) begin
            mismatch  <= 1'b1;
            err_count <= sat_inc16(err_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_readout_capture.sv
// Randomized bench for readout_capture with a frame-level reference model and a
// scoreboard of expected words consumed by an output monitor.
`timescale 1ns/1ps
module tb_readout_capture;

   localparam int unsigned DEPTH = 8;
   localparam int          SB_N  = 4096;

   logic        clk_in    = 1'b0;
   logic        resn      = 1'b0;
   logic        en        = 1'b0;
   logic        sdout     = 1'b0;
   logic [3:0]  sel       = 4'd0;
   logic        clr_ovf   = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [3:0]  out_chan;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic        abort;
   logic [31:0] word_count;
`ifdef READOUT_COMPARE_EN
   logic [7:0]  exp_data = 8'd0;
   logic        mismatch;
   logic [15:0] err_count;
`endif

   readout_capture #(.DEPTH(DEPTH)) dut (
      .clk_in     (clk_in),
      .resn       (resn),
      .en         (en),
      .sdout      (sdout),
      .sel        (sel),
      .clr_ovf    (clr_ovf),
      .out_ready  (out_ready),
`ifdef READOUT_COMPARE_EN
      .exp_data   (exp_data),
      .mismatch   (mismatch),
      .err_count  (err_count),
`endif
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_chan   (out_chan),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .abort      (abort),
      .word_count (word_count)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: frame assembly with integer arithmetic and an occupancy count.
   int exp_mem [SB_N];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int m_bits, m_acc, m_tag, m_pend, m_level;
   bit m_pend_v, m_ovf, m_abort, m_pop, m_drop;
   longint m_wc;
`ifdef READOUT_COMPARE_EN
   bit m_mis;
   int m_err;
`endif

   always @(posedge clk_in or negedge resn) begin
      if (!resn) begin
         m_bits = 0; m_acc = 0; m_tag = 0; m_pend = 0; m_level = 0;
         m_pend_v = 0; m_ovf = 0; m_abort = 0; m_wc = 0;
`ifdef READOUT_COMPARE_EN
         m_mis = 0; m_err = 0;
`endif
      end else begin
         m_pop  = (m_level > 0) && out_ready;
         m_drop = 0;
         if (m_pend_v) begin
            if (m_level < DEPTH || m_pop) begin
               exp_mem[wr_ptr % SB_N] = m_pend;
               wr_ptr++;
               m_wc = (m_wc + 1) % 64'h1_0000_0000;
               if (!m_pop) m_level++;
            end else begin
               m_drop = 1;
            end
         end else if (m_pop) begin
            m_level--;
         end
         if (m_drop) m_ovf = 1;
         else if (clr_ovf) m_ovf = 0;
         m_pend_v = 0;
         m_abort  = 0;
`ifdef READOUT_COMPARE_EN
         m_mis = 0;
`endif
         if (en) begin
            if (m_bits == 0) begin
               m_tag = int'(sel);
               m_acc = 0;
            end
            m_acc = m_acc * 2 + int'(sdout);
            m_bits++;
            if (m_bits == 8) begin
               m_pend_v = 1;
               m_pend   = m_tag * 256 + m_acc;
               m_bits   = 0;
`ifdef READOUT_COMPARE_EN
               if (m_acc != int'(exp_data)) begin
                  m_mis = 1;
                  if (m_err < 65535) m_err++;
               end
`endif
            end
         end else if (m_bits != 0) begin
            m_abort = 1;
            m_bits  = 0;
         end
      end
   end

   // Monitor: compares presented head against the scoreboard and consumes it on handshake.
   always @(negedge clk_in or negedge resn) begin
      if (!resn) begin
         rd_ptr = wr_ptr;
         #1;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_fifo_level", fifo_level, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_abort", abort, 0);
         chk("rst_word_count", word_count, 0);
         chk("rst_out_data", out_data, 0);
`ifdef READOUT_COMPARE_EN
         chk("rst_err_count", err_count, 0);
`endif
      end else begin
         chk("out_valid", out_valid, (rd_ptr != wr_ptr) ? 1 : 0);
         if (out_valid && rd_ptr != wr_ptr) begin
            chk("out_data", out_data, exp_mem[rd_ptr % SB_N] % 256);
            chk("out_chan", out_chan, exp_mem[rd_ptr % SB_N] / 256);
            if (out_ready) rd_ptr++;
         end
         chk("fifo_level", fifo_level, m_level);
         chk("overflow", overflow, m_ovf);
         chk("word_count", word_count, m_wc);
         chk("abort", abort, m_abort);
`ifdef READOUT_COMPARE_EN
         chk("mismatch", mismatch, m_mis);
         chk("err_count", err_count, m_err);
`endif
      end
   end

   task automatic drive(input logic e, input logic d, input logic [3:0] s, input logic r);
      en = e; sdout = d; sel = s; out_ready = r;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, r);
   endtask

   // rdy: 0 never, 1 always, 2 random
   task automatic frame(input logic [7:0] b, input logic [3:0] s, input int rdy);
`ifdef READOUT_COMPARE_EN
      exp_data = ($urandom_range(0, 1) == 1) ? b : b ^ 8'(1 << $urandom_range(0, 7));
`endif
      for (int i = 7; i >= 0; i--) begin
         drive(1'b1, b[i], s, (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1));
      end
   endtask

   task automatic do_reset();
      en = 1'b0;
      #2 resn = 1'b0;
      @(posedge clk_in);
      #1 resn = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk_in);
      #1 resn = 1'b1;

      // Directed 8'hA6 on channel 3, then drain.
      frame(8'hA6, 4'd3, 0);
      idle(2, 1'b0);
      idle(3, 1'b1);

      // Nine back-to-back frames without a consumer, then clear the flag and drain.
      for (int f = 0; f < 9; f++) frame(8'($urandom), 4'($urandom), 0);
      idle(2, 1'b0);
      clr_ovf = 1'b1;
      idle(1, 1'b0);
      clr_ovf = 1'b0;
      idle(10, 1'b1);

      // Full FIFO, ninth word arrives on the same edge as a pop.
      do_reset();
      for (int f = 0; f < 9; f++) frame(8'($urandom), 4'($urandom), 0);
      idle(1, 1'b1);
      idle(1, 1'b0);
      idle(10, 1'b1);

      // Aborted frame after 5 bits, then a clean frame.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 4'd9, 1'b0);
      idle(2, 1'b0);
      frame(8'h3C, 4'd5, 0);
      idle(3, 1'b1);

      // Reset with three words queued and a frame in flight.
      for (int f = 0; f < 3; f++) frame(8'($urandom), 4'($urandom), 0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'd7, 1'b0);
      do_reset();
      frame(8'h5A, 4'd12, 0);
      idle(3, 1'b1);

`ifdef READOUT_COMPARE_EN
      // Chip returns FE against FF, then a matching word.
      exp_data = 8'hFF;
      for (int i = 7; i >= 0; i--) drive(1'b1, (i != 0), 4'd1, 1'b1);
      exp_data = 8'h81;
      for (int i = 7; i >= 0; i--) drive(1'b1, (i == 0 || i == 7), 4'd2, 1'b1);
      idle(3, 1'b1);
`endif

      // Random traffic: en drops, clears, and both light and heavy consumer back-pressure.
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < 600; c++) begin
            clr_ovf = ($urandom_range(0, 7) == 0);
            drive(1'b1 & ($urandom_range(0, 15) != 0), 1'($urandom), 4'($urandom),
                  (ph == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0));
         end
         clr_ovf = 1'b0;
         idle(12, 1'b1);
      end

      for (int f = 0; f < 6; f++) frame(8'($urandom), 4'($urandom), 2);
      idle(12, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
